// File: rtl/sobel_result_sink.sv
// Frame-buffer sink for the Sobel result stream: stores each result and keeps per-frame
// edge count, checksum and sample count, with a registered random-access read port.
module sobel_result_sink #(
  parameter int unsigned OUT_W  = 126,
  parameter int unsigned OUT_H  = 126,
  parameter int unsigned ADDR_W = 14,
  parameter logic [15:0] THRESH = 16'd128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       conv_result,
  input  logic              conv_valid,
  input  logic              conv_end,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   wr_count,
  output logic [ADDR_W:0]   edge_count,
  output logic [31:0]       checksum,
  output logic              frame_done,
  output logic              mismatch,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned DEPTH   = OUT_W * OUT_H;
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t          state, state_next;
  logic            wr_en;
  logic            full;
  logic            rd_in_range;
  logic [ADDR_W:0] cnt_next, edge_next;
  logic [31:0]     sum_next;
  logic            done_next, mism_next, ovf_next;

  logic [15:0] mem [DEPTH];

  assign full        = (wr_count == DEPTH_C);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);

  // Next-state and statistics update; the write pointer is the stored-sample count.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    cnt_next   = wr_count;
    edge_next  = edge_count;
    sum_next   = checksum;
    done_next  = frame_done;
    mism_next  = mismatch;
    ovf_next   = overflow;
    if (clear) begin
      state_next = IDLE;
      cnt_next   = '0;
      edge_next  = '0;
      sum_next   = '0;
      done_next  = 1'b0;
      mism_next  = 1'b0;
      ovf_next   = 1'b0;
    end else begin
      case (state)
        IDLE, COLLECT: begin
          if (conv_valid) begin
            state_next = COLLECT;
            if (full) begin
              ovf_next = 1'b1;
            end else begin
              wr_en    = 1'b1;
              cnt_next = wr_count + ONE_C;
              sum_next = checksum + 32'(conv_result);
              if (conv_result >= THRESH) edge_next = edge_count + ONE_C;
            end
          end
          // End-of-frame wins over the COLLECT transition; a same-cycle sample is already counted.
          if (conv_end) begin
            state_next = DONE;
            done_next  = 1'b1;
            mism_next  = (cnt_next != DEPTH_C);
          end
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      wr_count   <= '0;
      edge_count <= '0;
      checksum   <= '0;
      frame_done <= 1'b0;
      mismatch   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_next;
      busy       <= (state_next == COLLECT);
      wr_count   <= cnt_next;
      edge_count <= edge_next;
      checksum   <= sum_next;
      frame_done <= done_next;
      mismatch   <= mism_next;
      overflow   <= ovf_next;
    end
  end

  // Buffer contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_count[IDX_W-1:0]] <= conv_result;
  end

  // Read-first registered read port; out-of-range addresses read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_in_range ? mem[rd_addr[IDX_W-1:0]] : 16'h0000;
    end
  end

endmodule

// File: tb/tb_sobel_result_sink.sv
// Bench for sobel_result_sink: queue-based frame model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sobel_result_sink;

  localparam int unsigned OUT_W  = 4;
  localparam int unsigned OUT_H  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned N      = OUT_W * OUT_H;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [15:0]       conv_result = '0;
  logic              conv_valid = 1'b0;
  logic              conv_end = 1'b0;
  logic              clear = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [15:0]       rd_data;
  logic              rd_valid;
  logic [ADDR_W:0]   wr_count, edge_count;
  logic [31:0]       checksum;
  logic              frame_done, mismatch, overflow, busy;

  sobel_result_sink #(.OUT_W(OUT_W), .OUT_H(OUT_H), .ADDR_W(ADDR_W), .THRESH(16'd100)) dut (
    .clk(clk), .rst_n(rst_n), .conv_result(conv_result), .conv_valid(conv_valid),
    .conv_end(conv_end), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_count(wr_count), .edge_count(edge_count),
    .checksum(checksum), .frame_done(frame_done), .mismatch(mismatch),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the frame is the list of accepted samples; statistics are derived from it.
  logic [15:0] m_mem [N];
  int          frame_q[$];
  bit          m_started = 0, m_done = 0, m_mism = 0, m_ovf = 0, m_rdv = 0;
  logic [15:0] m_rdd = '0;

  function automatic int q_sum();
    int s = 0;
    foreach (frame_q[i]) s += frame_q[i];
    return s;
  endfunction

  function automatic int q_edges();
    int e = 0;
    foreach (frame_q[i]) if (frame_q[i] >= 100) e++;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q.delete();
      m_started = 0; m_done = 0; m_mism = 0; m_ovf = 0; m_rdv = 0; m_rdd = '0;
    end else begin
      m_rdv = rd_en;
      if (rd_en) m_rdd = (int'(rd_addr) < N) ? m_mem[int'(rd_addr)] : 16'h0000;
      if (clear) begin
        frame_q.delete();
        m_started = 0; m_done = 0; m_mism = 0; m_ovf = 0;
      end else if (!m_done) begin
        if (conv_valid) begin
          m_started = 1;
          if (frame_q.size() == N) m_ovf = 1;
          else begin
            m_mem[frame_q.size()] = conv_result;
            frame_q.push_back(int'(conv_result));
          end
        end
        if (conv_end) begin
          m_done = 1;
          m_mism = (frame_q.size() != N);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_wr_count", 32'(wr_count), 32'(frame_q.size()));
      chk("m_edge_count", 32'(edge_count), 32'(q_edges()));
      chk("m_checksum", checksum, 32'(q_sum()));
      chk("m_frame_done", 32'(frame_done), 32'(m_done));
      chk("m_mismatch", 32'(mismatch), 32'(m_mism));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_busy", 32'(busy), 32'(m_started && !m_done));
      chk("m_rd_valid", 32'(rd_valid), 32'(m_rdv));
      chk("m_rd_data", 32'(rd_data), 32'(m_rdd));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v, input logic e);
    conv_valid = 1'b1; conv_result = v; conv_end = e;
    tick();
    conv_valid = 1'b0; conv_end = 1'b0;
  endtask

  task automatic end_pulse();
    conv_end = 1'b1;
    tick();
    conv_end = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic rd(input int a, input logic [15:0] exp, input string name);
    rd_en = 1'b1; rd_addr = ADDR_W'(a);
    tick();
    rd_en = 1'b0;
    chk(name, 32'(rd_data), 32'(exp));
    chk({name, "_valid"}, 32'(rd_valid), 32'd1);
  endtask

  initial begin
    tick(); tick();
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    rst_n = 1'b1;
    cmp_on = 1'b1;
    tick();

    // Full frame 0,10,..,150
    for (int i = 0; i < 16; i++) send(16'(i * 10), 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    end_pulse();
    chk("t1_wr_count", 32'(wr_count), 32'd16);
    chk("t1_edge_count", 32'(edge_count), 32'd6);
    chk("t1_checksum", checksum, 32'd1200);
    chk("t1_frame_done", 32'(frame_done), 32'd1);
    chk("t1_mismatch", 32'(mismatch), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);
    rd(5, 16'd50, "t1_rd5");
    tick();
    chk("t1_rd_valid_drop", 32'(rd_valid), 32'd0);

    // Short frame
    do_clear();
    for (int i = 0; i < 10; i++) send(16'(300 + i), 1'b0);
    end_pulse();
    chk("t2_wr_count", 32'(wr_count), 32'd10);
    chk("t2_mismatch", 32'(mismatch), 32'd1);
    rd(12, 16'd120, "t2_rd12");

    // Overflow
    do_clear();
    for (int i = 0; i < 18; i++) begin
      send(16'(1000 + i), 1'b0);
      if (i == 15) chk("t3_ovf_at16", 32'(overflow), 32'd0);
      if (i == 16) chk("t3_ovf_at17", 32'(overflow), 32'd1);
    end
    chk("t3_wr_count", 32'(wr_count), 32'd16);
    rd(15, 16'd1015, "t3_rd15");

    // Last sample with end in the same cycle
    do_clear();
    for (int i = 0; i < 15; i++) send(16'd5, 1'b0);
    send(16'd200, 1'b1);
    chk("t4_frame_done", 32'(frame_done), 32'd1);
    chk("t4_wr_count", 32'(wr_count), 32'd16);
    chk("t4_edge_count", 32'(edge_count), 32'd1);
    chk("t4_checksum", checksum, 32'd275);
    send(16'd7, 1'b0);
    send(16'd7, 1'b0);
    chk("t4_checksum_hold", checksum, 32'd275);
    rd(15, 16'd200, "t4_rd15");

    // Reset mid-frame
    do_clear();
    for (int i = 0; i < 7; i++) send(16'd9, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_async_rst", 32'(wr_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) send(16'(90 + i), 1'b0);
    end_pulse();
    chk("t5_wr_count", 32'(wr_count), 32'd16);
    chk("t5_edge_count", 32'(edge_count), 32'd6);
    chk("t5_checksum", checksum, 32'd1560);

    // Clear with a simultaneous valid in DONE
    conv_valid = 1'b1; conv_result = 16'd77; clear = 1'b1;
    tick();
    conv_valid = 1'b0; clear = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_frame_done", 32'(frame_done), 32'd0);
    chk("t6_wr_count", 32'(wr_count), 32'd0);
    chk("t6_checksum", checksum, 32'd0);
    rd(16, 16'd0, "t6_rd16");
    rd(0, 16'd90, "t6_rd0");

    // End with no samples
    end_pulse();
    chk("t7_frame_done", 32'(frame_done), 32'd1);
    chk("t7_mismatch", 32'(mismatch), 32'd1);
    chk("t7_wr_count", 32'(wr_count), 32'd0);
    tick(); tick();

    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_result_sink.md
# sobel_result_sink

Stream sink at the output end of the Sobel convolution datapath. Accepts the filter's result stream (`conv_result` qualified by `conv_valid`, frame end by `conv_end`) and stores each result in an on-chip frame buffer. Keeps per-frame statistics (edge count above threshold, checksum, sample count) and exposes a registered random-access read port, so the testbench or a downstream block can read the filtered image after the frame completes.

## Interface
Parameters:
- `OUT_W`, 126: result columns per frame.
- `OUT_H`, 126: result rows per frame.
- `ADDR_W`, 14: buffer address width; must satisfy 2^ADDR_W >= OUT_W*OUT_H.
- `THRESH`, 16'd128: edge threshold; a result >= THRESH (unsigned) counts as an edge.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `conv_result`  in  16  unsigned convolution magnitude.
- `conv_valid`  in  1  `conv_result` is valid this cycle (filter `enable`).
- `conv_end`  in  1  filter end-of-frame flag (`endSign`), level or pulse.
- `clear`  in  1  one-cycle pulse; re-arms the block for the next frame.
- `rd_en`  in  1  read request.
- `rd_addr`  in  ADDR_W  read address (row*OUT_W + col).
- `rd_data`  out  16  read data.
- `rd_valid`  out  1  `rd_data` valid.
- `wr_count`  out  ADDR_W+1  results stored this frame.
- `edge_count`  out  ADDR_W+1  stored results >= THRESH.
- `checksum`  out  32  sum of stored results, modulo 2^32.
- `frame_done`  out  1  frame closed, statistics final.
- `mismatch`  out  1  frame closed with `wr_count` != OUT_W*OUT_H.
- `overflow`  out  1  sticky; a valid arrived after the buffer was full.
- `busy`  out  1  state is COLLECT.

## Operation
- Memory: OUT_W*OUT_H x 16, single write port, single registered read port, read-first.
- FSM states IDLE, COLLECT, DONE.
  - IDLE: first `conv_valid` writes `mem[0]`; transition to COLLECT. `conv_end` without prior valid -> DONE with `wr_count`=0, `mismatch`=1.
  - COLLECT: every `conv_valid` writes `mem[wr_ptr]`; `wr_ptr`, `wr_count`, `checksum` update; `edge_count` increments if result >= THRESH. `conv_end` -> DONE.
  - DONE: `frame_done`=1; `conv_valid` and `conv_end` ignored; `clear` -> IDLE.
- `conv_valid` and `conv_end` in the same cycle: sample is stored and counted, then the FSM moves to DONE.
- Full: when `wr_count` = OUT_W*OUT_H, further valids are dropped (no write, no stat update) and `overflow` is set; it stays set until `clear` or reset.
- `mismatch` is evaluated on entry to DONE and held until `clear`.
- `clear` in any state: zeroes `wr_ptr`, counters, `checksum`, `overflow`, `mismatch`, `frame_done` and enters IDLE. `clear` has priority over a simultaneous `conv_valid`, which is dropped.
- Reads are allowed in every state. `rd_addr` >= OUT_W*OUT_H returns 16'h0000 with `rd_valid`=1.
- Reset: state IDLE; all outputs 0; buffer contents are not cleared. Reset mid-frame abandons the frame.

## Timing
- Write: a sample valid at edge N is in memory after edge N. Counters and `checksum` reflect it after edge N.
- Read latency is 1 cycle: `rd_en` at edge N -> `rd_data`/`rd_valid` after edge N. `rd_valid` drops the cycle after `rd_en` deasserts. `rd_data` holds its last value.
- Same-cycle read and write to the same address returns the old data.
- `frame_done`/`mismatch` assert 1 cycle after the `conv_end` edge. `busy` follows the registered state.
- Sustains one sample per cycle; no backpressure to the filter.

## Test plan
Use OUT_W=4, OUT_H=4, THRESH=100.
- Reset then 16 valids with values 0..15 x 10, then `conv_end` -> `wr_count`=16, `edge_count`=6, `checksum`=1200, `frame_done`=1, `mismatch`=0, `overflow`=0. Reading addr 5 gives 50 one cycle later.
- 10 valids then `conv_end` -> `wr_count`=10, `mismatch`=1. Reading addr 12 returns the previous frame's data.
- 18 valids without `conv_end` -> `overflow`=1 from the 17th. `wr_count`=16. `mem[15]` keeps the 16th value.
- Last valid (value 200) and `conv_end` in the same cycle -> sample is counted, `edge_count` includes it, DONE next cycle. Later valids do not change `checksum`.
- `rst_n` low after 7 valids, then a full 16-sample frame -> counters restart from 0 and final `checksum` covers only the new frame.
- `clear` in the same cycle as a valid in DONE -> IDLE, all stats 0. A read of addr 16 returns 0 with `rd_valid`=1.
